// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the clock mode/adjust controller: state encoding,
// display field indices and helpers mapping an edit state to its field.
package time_set_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_MIN  = 3'd1,
    ST_SET_HOUR = 3'd2,
    ST_SET_DAY  = 3'd3,
    ST_SET_MON  = 3'd4,
    ST_SET_YEAR = 3'd5
  } state_e;

  localparam int NUM_FIELDS = 6;
  localparam int F_SEC  = 0;
  localparam int F_MIN  = 1;
  localparam int F_HOUR = 2;
  localparam int F_DAY  = 3;
  localparam int F_MON  = 4;
  localparam int F_YEAR = 5;

  function automatic logic [NUM_FIELDS-1:0] field_onehot(input state_e st);
    logic [NUM_FIELDS-1:0] v;
    v = '0;
    case (st)
      ST_SET_MIN:  v[F_MIN]  = 1'b1;
      ST_SET_HOUR: v[F_HOUR] = 1'b1;
      ST_SET_DAY:  v[F_DAY]  = 1'b1;
      ST_SET_MON:  v[F_MON]  = 1'b1;
      ST_SET_YEAR: v[F_YEAR] = 1'b1;
      default:     v = '0;
    endcase
    return v;
  endfunction

  // Mode button walks the fields from finest to coarsest, then back to RUN.
  function automatic state_e next_mode(input state_e st);
    state_e n;
    case (st)
      ST_RUN:      n = ST_SET_MIN;
      ST_SET_MIN:  n = ST_SET_HOUR;
      ST_SET_HOUR: n = ST_SET_DAY;
      ST_SET_DAY:  n = ST_SET_MON;
      ST_SET_MON:  n = ST_SET_YEAR;
      default:     n = ST_RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_repeat.sv
// One adjust button: rising-edge step plus hold-to-auto-repeat. A button only
// counts as pressed while the opposite button is released.
module btn_repeat
  import time_set_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES   = 24_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_lvl,
  input  logic i_other,
  output logic o_step,
  output logic o_held
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             r_prev;
  logic             r_rep;
  logic [CNT_W-1:0] r_cnt;
  logic             w_lvl;
  logic             w_act;
  logic             w_rise;
  logic             w_fire;

  // The edge tracker follows the level even when disabled, so entering an
  // edit state with a button already down does not fake a fresh press.
  assign w_lvl  = i_lvl & ~i_other;
  assign w_act  = i_en & w_lvl;
  assign w_rise = w_act & ~r_prev;
  assign w_fire = w_act & r_prev & (r_cnt == (r_rep ? REP_LAST : HOLD_LAST));

  assign o_step = w_rise | w_fire;
  assign o_held = i_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_rep  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_prev <= w_lvl;
      if (!w_act) begin
        r_rep <= 1'b0;
        r_cnt <= '0;
      end else if (w_fire) begin
        r_rep <= 1'b1;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Mode/adjust controller for the seconds..year counter chain: RUN forwards the
// 1 Hz tick, SET states step one field from inc/dec, and a blink mask is made.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES   = 24_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int TIMEOUT_S     = 30,
  parameter int CNT_W         = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_tick_1hz,
  input  logic                  i_btn_mode,
  input  logic                  i_inc_lvl,
  input  logic                  i_dec_lvl,
  output logic [NUM_FIELDS-1:0] o_en_field,
  output logic                  o_up,
  output logic                  o_down,
  output logic                  o_set_mode,
  output logic [NUM_FIELDS-1:0] o_blink_mask,
  output state_e                o_dbg_state
);

  localparam int TO_W = $clog2(TIMEOUT_S + 1);

  state_e                r_state;
  state_e                w_next;
  logic [TO_W-1:0]       r_to;
  logic                  r_phase;
  logic [NUM_FIELDS-1:0] r_en;
  logic                  r_up;
  logic                  r_down;
  logic                  r_set;
  logic [NUM_FIELDS-1:0] r_blink;

  logic w_in_set;
  logic w_step_inc;
  logic w_step_dec;
  logic w_held_inc;
  logic w_held_dec;
  logic w_any_held;
  logic w_raw_step;
  logic w_step;
  logic w_timeout;
  logic w_phase_next;

  assign w_in_set = (r_state != ST_RUN);

  btn_repeat #(
    .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .CNT_W(CNT_W)
  ) u_inc (
    .clk(clk), .rst_n(rst_n), .i_en(w_in_set), .i_lvl(i_inc_lvl),
    .i_other(i_dec_lvl), .o_step(w_step_inc), .o_held(w_held_inc)
  );

  btn_repeat #(
    .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .CNT_W(CNT_W)
  ) u_dec (
    .clk(clk), .rst_n(rst_n), .i_en(w_in_set), .i_lvl(i_dec_lvl),
    .i_other(i_inc_lvl), .o_step(w_step_dec), .o_held(w_held_dec)
  );

  assign w_any_held   = w_held_inc | w_held_dec;
  assign w_raw_step   = w_step_inc | w_step_dec;
  assign w_step       = w_raw_step & ~i_btn_mode;
  assign w_phase_next = r_phase ^ i_tick_1hz;
  assign w_timeout    = w_in_set & i_tick_1hz & ~i_btn_mode & ~w_raw_step &
                        ~w_any_held & (r_to == TO_W'(TIMEOUT_S - 1));

  always_comb begin
    w_next = r_state;
    if (i_btn_mode) begin
      w_next = next_mode(r_state);
    end else if (w_timeout) begin
      w_next = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_to    <= '0;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_next;
      r_phase <= w_phase_next;
      if (!w_in_set || i_btn_mode || w_raw_step || w_any_held || w_timeout) begin
        r_to <= '0;
      end else if (i_tick_1hz) begin
        r_to <= r_to + TO_W'(1);
      end
    end
  end

  // Enables are judged on the current state, so the tick that exits SET does
  // not leak into seconds; direction and flags follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en    <= '0;
      r_up    <= 1'b1;
      r_down  <= 1'b0;
      r_set   <= 1'b0;
      r_blink <= '0;
    end else begin
      r_set   <= (w_next != ST_RUN);
      r_blink <= ((w_next != ST_RUN) && w_phase_next && !w_any_held) ?
                 field_onehot(w_next) : '0;
      if (!w_in_set) begin
        r_en <= {{(NUM_FIELDS-1){1'b0}}, i_tick_1hz};
      end else begin
        r_en <= w_step ? field_onehot(r_state) : '0;
      end
      if (w_next == ST_RUN) begin
        r_up   <= 1'b1;
        r_down <= 1'b0;
      end else if (w_step) begin
        r_up   <= w_step_inc;
        r_down <= w_step_dec;
      end
    end
  end

  assign o_en_field   = r_en;
  assign o_up         = r_up;
  assign o_down       = r_down;
  assign o_set_mode   = r_set;
  assign o_blink_mask = r_blink;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl with short hold/repeat/timeout parameters: a vector
// table for single-cycle behaviour plus sequences for repeat, timeout, reset.
`timescale 1ns/1ps
module tb_time_set_ctrl;
  import time_set_ctrl_pkg::*;

  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int TOUT = 3;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tick  = 1'b0;
  logic mode  = 1'b0;
  logic inc   = 1'b0;
  logic dec   = 1'b0;
  logic [5:0] en_field;
  logic [5:0] blink;
  logic       up;
  logic       down;
  logic       set_mode;
  state_e     dbg_state;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .TIMEOUT_S(TOUT), .CNT_W(25)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .i_tick_1hz(tick), .i_btn_mode(mode),
    .i_inc_lvl(inc), .i_dec_lvl(dec), .o_en_field(en_field), .o_up(up),
    .o_down(down), .o_set_mode(set_mode), .o_blink_mask(blink),
    .o_dbg_state(dbg_state)
  );

  // scoreboard: {state[2:0], en[5:0], up, down, set_mode, blink[5:0]}
  logic [17:0] exp_q[$];
  string       name_q[$];
  int          total = 0;
  int          bad   = 0;
  logic        tb_phase = 1'b0;

  typedef struct {
    logic   t;
    logic   m;
    logic   i;
    logic   d;
    state_e es;
    logic [5:0] ee;
    logic   eu;
    logic   ed;
    string  nm;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [5:0] tb_onehot(input state_e st);
    case (st)
      ST_SET_MIN:  return 6'b000010;
      ST_SET_HOUR: return 6'b000100;
      ST_SET_DAY:  return 6'b001000;
      ST_SET_MON:  return 6'b010000;
      ST_SET_YEAR: return 6'b100000;
      default:     return 6'b000000;
    endcase
  endfunction

  task automatic compare(input logic [17:0] e, input string nm);
    logic [17:0] a;
    a = {dbg_state, en_field, up, down, set_mode, blink};
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got st=%0d en=%b up=%b dn=%b set=%b blink=%b, want st=%0d en=%b up=%b dn=%b set=%b blink=%b",
               nm, a[17:15], a[14:9], a[8], a[7], a[6], a[5:0],
               e[17:15], e[14:9], e[8], e[7], e[6], e[5:0]);
    end
  endtask

  task automatic check_pending();
    if (exp_q.size() > 0) compare(exp_q.pop_front(), name_q.pop_front());
  endtask

  // driver: apply one cycle of inputs and queue the outputs expected after it
  task automatic cyc(input logic t, input logic m, input logic i, input logic d,
                     input state_e es, input logic [5:0] ee, input logic eu,
                     input logic ed, input string nm);
    logic [5:0] eb;
    @(negedge clk);
    check_pending();
    tick = t; mode = m; inc = i; dec = d;
    tb_phase = tb_phase ^ t;
    eb = ((es != ST_RUN) && tb_phase && !(i || d)) ? tb_onehot(es) : 6'b0;
    exp_q.push_back({es, ee, eu, ed, (es != ST_RUN), eb});
    name_q.push_back(nm);
  endtask

  task automatic add(input logic t, input logic m, input logic i, input logic d,
                     input state_e es, input logic [5:0] ee, input logic eu,
                     input logic ed, input string nm);
    vec_t v;
    v.t = t; v.m = m; v.i = i; v.d = d; v.es = es; v.ee = ee;
    v.eu = eu; v.ed = ed; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #1;
    check_pending();
    rst_n = 1'b0;
    #1;
    compare({ST_RUN, 6'b0, 1'b1, 1'b0, 1'b0, 6'b0}, "async_reset");
    tb_phase = 1'b0;
    @(posedge clk);
    #1;
    compare({ST_RUN, 6'b0, 1'b1, 1'b0, 1'b0, 6'b0}, "reset_held");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // single-cycle behaviour table
    add(0,0,0,0, ST_RUN,      6'b000000, 1,0, "run_idle");
    add(1,0,0,0, ST_RUN,      6'b000001, 1,0, "run_tick1");
    add(0,0,0,0, ST_RUN,      6'b000000, 1,0, "run_after_tick1");
    add(1,0,0,0, ST_RUN,      6'b000001, 1,0, "run_tick2");
    add(0,0,0,0, ST_RUN,      6'b000000, 1,0, "run_after_tick2");
    add(0,0,1,0, ST_RUN,      6'b000000, 1,0, "run_inc_ignored");
    add(1,0,0,0, ST_RUN,      6'b000001, 1,0, "run_tick3");
    add(0,0,0,0, ST_RUN,      6'b000000, 1,0, "run_after_tick3");
    add(0,1,0,0, ST_SET_MIN,  6'b000000, 1,0, "mode_to_min");
    add(1,0,0,0, ST_SET_MIN,  6'b000000, 1,0, "set_tick_silent");
    add(0,1,0,0, ST_SET_HOUR, 6'b000000, 1,0, "mode_to_hour");
    add(1,0,0,0, ST_SET_HOUR, 6'b000000, 1,0, "hour_tick_silent");
    add(0,0,1,0, ST_SET_HOUR, 6'b000100, 1,0, "inc_hour");
    add(0,0,0,0, ST_SET_HOUR, 6'b000000, 1,0, "inc_hour_done");
    add(0,0,0,1, ST_SET_HOUR, 6'b000100, 0,1, "dec_hour");
    add(0,0,0,0, ST_SET_HOUR, 6'b000000, 0,1, "dir_holds");
    add(0,1,1,0, ST_SET_DAY,  6'b000000, 0,1, "mode_beats_step");
    add(0,0,0,0, ST_SET_DAY,  6'b000000, 0,1, "day_idle");

    repeat (3) @(negedge clk);
    compare({ST_RUN, 6'b0, 1'b1, 1'b0, 1'b0, 6'b0}, "reset_state");
    rst_n = 1'b1;

    foreach (vecs[n])
      cyc(vecs[n].t, vecs[n].m, vecs[n].i, vecs[n].d,
          vecs[n].es, vecs[n].ee, vecs[n].eu, vecs[n].ed, vecs[n].nm);

    // both buttons held: no steps, no timeout, hold counters idle
    for (int k = 0; k < 20; k++)
      cyc((k % 5 == 4), 0, 1, 1, ST_SET_DAY, 6'b0, 0, 1, "both_held");
    total++;
    if ((u_dut.u_inc.r_cnt | u_dut.u_dec.r_cnt) !== 25'd0) begin
      bad++;
      $display("FAIL both_held_cnt: got inc=%0d dec=%0d, want 0",
               u_dut.u_inc.r_cnt, u_dut.u_dec.r_cnt);
    end
    cyc(0,0,0,0, ST_SET_DAY, 6'b0, 0,1, "both_release");
    cyc(0,1,0,0, ST_SET_MON, 6'b0, 0,1, "mode_to_mon");

    // timeout after three idle ticks, then seconds resume on the next tick
    cyc(1,0,0,0, ST_SET_MON, 6'b0, 0,1, "to_tick1");
    cyc(0,0,0,0, ST_SET_MON, 6'b0, 0,1, "to_gap1");
    cyc(1,0,0,0, ST_SET_MON, 6'b0, 0,1, "to_tick2");
    cyc(0,0,0,0, ST_SET_MON, 6'b0, 0,1, "to_gap2");
    cyc(1,0,0,0, ST_RUN,     6'b0, 1,0, "to_exit");
    cyc(0,0,0,0, ST_RUN,     6'b0, 1,0, "run_after_exit");
    cyc(1,0,0,0, ST_RUN, 6'b000001, 1,0, "first_sec_after_exit");
    cyc(0,0,0,0, ST_RUN,     6'b0, 1,0, "run_idle2");

    // dec held 20 cycles in SET_MIN: step on press, then held cycles 8,12,16,20
    cyc(0,1,0,0, ST_SET_MIN, 6'b0, 1,0, "mode_to_min2");
    for (int k = 0; k < 20; k++)
      cyc(0,0,0,1, ST_SET_MIN,
          (k == 0 || k == 7 || k == 11 || k == 15 || k == 19) ? 6'b000010 : 6'b0,
          0, 1, "dec_repeat");
    cyc(0,0,0,0, ST_SET_MIN, 6'b0, 0,1, "dec_release");

    // walk to SET_YEAR, hold dec into the repeat phase, then reset
    cyc(0,1,0,0, ST_SET_HOUR, 6'b0, 0,1, "walk_hour");
    cyc(0,1,0,0, ST_SET_DAY,  6'b0, 0,1, "walk_day");
    cyc(0,1,0,0, ST_SET_MON,  6'b0, 0,1, "walk_mon");
    cyc(0,1,0,0, ST_SET_YEAR, 6'b0, 0,1, "walk_year");
    for (int k = 0; k < 10; k++)
      cyc(0,0,0,1, ST_SET_YEAR, (k == 0 || k == 7) ? 6'b100000 : 6'b0,
          0, 1, "dec_year");
    reset_mid();
    for (int k = 0; k < 12; k++)
      cyc(0,0,0,1, ST_RUN, 6'b0, 1,0, "post_reset_quiet");
    cyc(1,0,0,1, ST_RUN, 6'b000001, 1,0, "post_reset_tick");
    cyc(0,0,0,0, ST_RUN, 6'b0, 1,0, "post_reset_idle");
    @(negedge clk);
    check_pending();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
